// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
package mc_pkg;

  localparam int unsigned INSTR_W = 20;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned FLAG_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
  } ctrl_t;

  localparam ctrl_t FETCH_OUT = '{pc_write: 1'b1, adr_src: 1'b0, mem_write: 1'b0,
                                  ir_write: 1'b1, reg_write: 1'b0,
                                  result_src: RES_ALURESULT, alu_src_a: 1'b1,
                                  alu_src_b: SRCB_FOUR, alu_control: ALU_ADD,
                                  imm_src: IMM_8, reg_src: 2'b00};

  typedef struct packed {
    logic [1:0] alu_control;
    logic       no_write;
    logic       wr_nz;
    logic       wr_cv;
  } alu_dec_t;

  // Data-processing cmd field to ALU op, result suppression and flag-write classes.
  function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
    alu_dec_t d;
    case (cmd)
      4'b0100: d = '{alu_control: ALU_ADD, no_write: 1'b0, wr_nz: 1'b1, wr_cv: 1'b1};
      4'b0010: d = '{alu_control: ALU_SUB, no_write: 1'b0, wr_nz: 1'b1, wr_cv: 1'b1};
      4'b0000: d = '{alu_control: ALU_AND, no_write: 1'b0, wr_nz: 1'b1, wr_cv: 1'b0};
      4'b1100: d = '{alu_control: ALU_ORR, no_write: 1'b0, wr_nz: 1'b1, wr_cv: 1'b0};
      4'b1010: d = '{alu_control: ALU_SUB, no_write: 1'b1, wr_nz: 1'b1, wr_cv: 1'b1};
      4'b1000: d = '{alu_control: ALU_AND, no_write: 1'b1, wr_nz: 1'b1, wr_cv: 1'b0};
      default: d = '{alu_control: ALU_ADD, no_write: 1'b1, wr_nz: 1'b0, wr_cv: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and ALU flags in, enables and selects out.
interface mc_ctrl_if;
  logic [mc_pkg::INSTR_W-1:0] Instr;
  logic [mc_pkg::FLAG_W-1:0]  ALUFlags;
  logic                       PCWrite;
  logic                       AdrSrc;
  logic                       MemWrite;
  logic                       IRWrite;
  logic                       RegWrite;
  logic [1:0]                 ResultSrc;
  logic                       ALUSrcA;
  logic [1:0]                 ALUSrcB;
  logic [1:0]                 ALUControl;
  logic [1:0]                 ImmSrc;
  logic [1:0]                 RegSrc;
  logic [mc_pkg::STATE_W-1:0] State;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
  );
endinterface

// File: rtl/mc_cond_unit.sv
// NZCV flag register, ARM condition evaluation and the per-instruction cond_ok latch.
module mc_cond_unit
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cond_i,
  input  logic [FLAG_W-1:0] alu_flags_i,
  input  logic              latch_i,
  input  logic              wr_nz_i,
  input  logic              wr_cv_i,
  output logic              cond_ok_o,
  output logic              cond_ok_d_o
);

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              cond_ok_q, cond_ok_d;
  logic              cond_eval;
  logic              n, z, c, v;

  always_comb begin
    {n, z, c, v} = flags_q;
    case (cond_i)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = ~z;
      4'h2:    cond_eval = c;
      4'h3:    cond_eval = ~c;
      4'h4:    cond_eval = n;
      4'h5:    cond_eval = ~n;
      4'h6:    cond_eval = v;
      4'h7:    cond_eval = ~v;
      4'h8:    cond_eval = c & ~z;
      4'h9:    cond_eval = ~c | z;
      4'hA:    cond_eval = (n == v);
      4'hB:    cond_eval = (n != v);
      4'hC:    cond_eval = ~z & (n == v);
      4'hD:    cond_eval = z | (n != v);
      4'hE:    cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (wr_nz_i) flags_d[3:2] = alu_flags_i[3:2];
    if (wr_cv_i) flags_d[1:0] = alu_flags_i[1:0];
  end

  assign cond_ok_d   = latch_i ? cond_eval : cond_ok_q;
  assign cond_ok_o   = cond_ok_q;
  assign cond_ok_d_o = cond_ok_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= '0;
      cond_ok_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ok_q <= cond_ok_d;
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle Moore controller: sequences fetch/decode/execute and drives all datapath controls.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master ctrl
);

  state_e     state_q, state_d;
  ctrl_t      out_q, out_d;
  alu_dec_t   alu_dec;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       rd_pc;
  logic       cond_ok_q, cond_ok_d;
  logic       flag_set;
  logic       unused_rn;

  assign cond      = ctrl.Instr[19:16];
  assign op        = ctrl.Instr[15:14];
  assign funct     = ctrl.Instr[13:8];
  assign rd        = ctrl.Instr[3:0];
  assign unused_rn = ^ctrl.Instr[7:4];
  assign rd_pc     = (rd == 4'hF);
  assign alu_dec   = alu_decode(funct[4:1]);
  assign flag_set  = (state_q inside {EXECR, EXECI}) & funct[0] & cond_ok_q;

  mc_cond_unit u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (cond),
    .alu_flags_i (ctrl.ALUFlags),
    .latch_i     (state_q == DECODE),
    .wr_nz_i     (flag_set & alu_dec.wr_nz),
    .wr_cv_i     (flag_set & alu_dec.wr_cv),
    .cond_ok_o   (cond_ok_q),
    .cond_ok_d_o (cond_ok_d)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:       state_d = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:      state_d = MEMWB;
      EXECR, EXECI: state_d = ALUWB;
      default:      state_d = FETCH;
    endcase
  end

  // Outputs are decoded for the state being entered so they register alongside it.
  always_comb begin
    out_d = '0;
    case (state_d)
      FETCH:  out_d = FETCH_OUT;
      DECODE: begin
        out_d.alu_src_a  = 1'b1;
        out_d.alu_src_b  = SRCB_FOUR;
        out_d.result_src = RES_ALURESULT;
      end
      MEMADR: begin
        out_d.alu_src_b  = SRCB_IMM;
        out_d.imm_src    = IMM_12;
        out_d.reg_src[1] = ~funct[0];
      end
      MEMREAD: out_d.adr_src = 1'b1;
      MEMWB: begin
        out_d.result_src = RES_DATA;
        out_d.reg_write  = cond_ok_d;
        out_d.pc_write   = cond_ok_d & rd_pc;
      end
      MEMWRITE: begin
        out_d.adr_src    = 1'b1;
        out_d.mem_write  = cond_ok_d;
        out_d.reg_src[1] = 1'b1;
      end
      EXECR: out_d.alu_control = alu_dec.alu_control;
      EXECI: begin
        out_d.alu_src_b   = SRCB_IMM;
        out_d.imm_src     = IMM_8;
        out_d.alu_control = alu_dec.alu_control;
      end
      ALUWB: begin
        out_d.reg_write = cond_ok_d & ~alu_dec.no_write;
        out_d.pc_write  = cond_ok_d & ~alu_dec.no_write & rd_pc;
      end
      BRANCH: begin
        out_d.reg_src[0] = 1'b1;
        out_d.alu_src_b  = SRCB_IMM;
        out_d.imm_src    = IMM_24;
        out_d.result_src = RES_ALURESULT;
        out_d.pc_write   = cond_ok_d;
      end
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      out_q   <= FETCH_OUT;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Write strobes are masked immediately so a reset mid-instruction never completes a write.
  assign ctrl.PCWrite    = out_q.pc_write  & ~reset;
  assign ctrl.IRWrite    = out_q.ir_write  & ~reset;
  assign ctrl.RegWrite   = out_q.reg_write & ~reset;
  assign ctrl.MemWrite   = out_q.mem_write & ~reset;
  assign ctrl.AdrSrc     = out_q.adr_src;
  assign ctrl.ResultSrc  = out_q.result_src;
  assign ctrl.ALUSrcA    = out_q.alu_src_a;
  assign ctrl.ALUSrcB    = out_q.alu_src_b;
  assign ctrl.ALUControl = out_q.alu_control;
  assign ctrl.ImmSrc     = out_q.imm_src;
  assign ctrl.RegSrc     = out_q.reg_src;
  assign ctrl.State      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected controls queued from a reference model.
module tb_mc_ctrl;
  import mc_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb, aluc, imm, regsrc;
  } obs_t;

  logic clk = 1'b0;
  logic reset;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  always #5 clk = ~clk;

  obs_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] flags_m  = 4'b0000;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected controls for one cycle, written from the state table.
  function automatic obs_t model(input state_e st, input logic [31:0] ins,
                                 input logic ok, input logic rst);
    obs_t o;
    logic nw;
    logic [1:0] aluc;
    logic rd15;
    o    = '0;
    o.st = st;
    rd15 = (ins[15:12] == 4'hF);
    case (ins[24:21])
      4'b0100: begin aluc = 2'b00; nw = 1'b0; end
      4'b0010: begin aluc = 2'b01; nw = 1'b0; end
      4'b0000: begin aluc = 2'b10; nw = 1'b0; end
      4'b1100: begin aluc = 2'b11; nw = 1'b0; end
      4'b1010: begin aluc = 2'b01; nw = 1'b1; end
      4'b1000: begin aluc = 2'b10; nw = 1'b1; end
      default: begin aluc = 2'b00; nw = 1'b1; end
    endcase
    case (st)
      FETCH:    begin o.irw = 1; o.srca = 1; o.srcb = 2'b10; o.res = 2'b10; o.pcw = 1; end
      DECODE:   begin o.srca = 1; o.srcb = 2'b10; o.res = 2'b10; end
      MEMADR:   begin o.srcb = 2'b01; o.imm = 2'b01; o.regsrc = {!ins[20], 1'b0}; end
      MEMREAD:  o.adr = 1;
      MEMWB:    begin o.res = 2'b01; o.regw = ok; o.pcw = ok && rd15; end
      MEMWRITE: begin o.adr = 1; o.memw = ok; o.regsrc = 2'b10; end
      EXECR:    o.aluc = aluc;
      EXECI:    begin o.srcb = 2'b01; o.aluc = aluc; end
      ALUWB:    begin o.regw = ok && !nw; o.pcw = ok && !nw && rd15; end
      BRANCH:   begin o.regsrc = 2'b01; o.srcb = 2'b01; o.imm = 2'b10; o.res = 2'b10; o.pcw = ok; end
      default:  o = '0;
    endcase
    if (rst) begin
      o.pcw = 0; o.irw = 0; o.regw = 0; o.memw = 0;
    end
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{st: bus.State, pcw: bus.PCWrite, adr: bus.AdrSrc, memw: bus.MemWrite,
          irw: bus.IRWrite, regw: bus.RegWrite, res: bus.ResultSrc, srca: bus.ALUSrcA,
          srcb: bus.ALUSrcB, aluc: bus.ALUControl, imm: bus.ImmSrc, regsrc: bus.RegSrc};
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Drive one instruction from FETCH; abort_at >= 0 raises reset in that cycle.
  task automatic run(input string name, input logic [31:0] ins,
                     input logic [3:0] aflags, input int abort_at);
    state_e seq[$];
    logic   ok;
    int     n;
    ok = cond_pass(ins[31:28], flags_m);
    seq.push_back(FETCH);
    seq.push_back(DECODE);
    case (ins[27:26])
      2'b01: begin
        seq.push_back(MEMADR);
        if (ins[20]) begin seq.push_back(MEMREAD); seq.push_back(MEMWB); end
        else seq.push_back(MEMWRITE);
      end
      2'b00: begin
        if (ins[25]) seq.push_back(EXECI); else seq.push_back(EXECR);
        seq.push_back(ALUWB);
      end
      2'b10: seq.push_back(BRANCH);
      default: ;
    endcase
    n = (abort_at >= 0) ? abort_at + 1 : seq.size();
    for (int i = 0; i < n; i++) exp_q.push_back(model(seq[i], ins, ok, i == abort_at));
    if (abort_at >= 0) exp_q.push_back(model(FETCH, ins, ok, 1'b1));
    bus.Instr    = ins[31:12];
    bus.ALUFlags = aflags;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) reset = 1'b1;
      @(negedge clk);
      check($sformatf("%s[%0d]", name, i), sample(), exp_q.pop_front());
      @(posedge clk); #1;
    end
    if (abort_at >= 0) begin
      @(negedge clk);
      check($sformatf("%s_reset", name), sample(), exp_q.pop_front());
      @(posedge clk); #1;
      reset = 1'b0;
    end else if (ins[27:26] == 2'b00 && ins[20] && ok) begin
      case (ins[24:21])
        4'b0100, 4'b0010, 4'b1010: flags_m = aflags;
        4'b0000, 4'b1100, 4'b1000: flags_m[3:2] = aflags[3:2];
        default: ;
      endcase
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.Instr    = '0;
    bus.ALUFlags = '0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(FETCH, 32'h0, 1'b0, 1'b1));
      @(negedge clk);
      check($sformatf("reset[%0d]", i), sample(), exp_q.pop_front());
    end
    @(posedge clk); #1;
    reset = 1'b0;

    run("add_imm",  32'hE2802005, 4'b0000, -1);
    run("subs",     32'hE0513001, 4'b0110, -1);
    run("addeq_t",  32'h02804001, 4'b0000, -1);
    run("addne_f",  32'h12804001, 4'b0000, -1);
    run("cmp_imm",  32'hE3510007, 4'b0110, -1);
    run("ands",     32'hE2105001, 4'b1001, -1);
    run("undef_s",  32'hE0300001, 4'b0100, -1);
    run("addeq_f",  32'h02804001, 4'b0000, -1);
    run("addcs_t",  32'h22804001, 4'b0000, -1);
    run("addvs_f",  32'h62804001, 4'b0000, -1);
    run("addlt_t",  32'hB2804001, 4'b0000, -1);
    run("ldr",      32'hE5910004, 4'b0000, -1);
    run("str",      32'hE5812040, 4'b0000, -1);
    run("ldr_pc",   32'hE591F004, 4'b0000, -1);
    run("beq_f",    32'h0A000002, 4'b0000, -1);
    run("b_al",     32'hEAFFFFFE, 4'b0000, -1);
    run("nop_op11", 32'hEC000000, 4'b0000, -1);
    run("cond_nv",  32'hF2802005, 4'b0000, -1);
    run("add_pc",   32'hE080F001, 4'b0000, -1);
    run("str_abrt", 32'hE5812040, 4'b0000, 3);
    run("add_post", 32'hE2802005, 4'b0000, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
